// File: rtl/ahbl_splitter_n.sv
// N-way AHB-Lite address decoder / response mux with a built-in ERROR default subordinate.
// Optional wait-state watchdog: define AHBL_SPLITTER_TIMEOUT_EN.
module ahbl_splitter_n #(
    parameter int unsigned   N_SLAVES       = 3,
    parameter logic [31:0]   ADDR_MASK      = 32'hF000_0000,
    parameter logic [511:0]  SLAVE_BASE     = 512'({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    parameter int unsigned   TIMEOUT_CYCLES = 256
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    output logic                     HREADY,
    output logic [31:0]              HRDATA,
    output logic                     HRESP,
    output logic [N_SLAVES-1:0]      S_HSEL,
    input  logic [32*N_SLAVES-1:0]   S_HRDATA,
    input  logic [N_SLAVES-1:0]      S_HREADYOUT,
    input  logic [N_SLAVES-1:0]      S_HRESP,
    output logic [15:0]              ERR_COUNT
);
    localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {SEL_NONE, SEL_SLOT, SEL_DFLT} sel_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} st_e;

    sel_e          sel_q, sel_d;
    logic [IW-1:0] idx_q, idx_d;
    st_e           state_q, state_d;
    logic [15:0]   err_q, err_d;

    logic          hit_any;
    logic [IW-1:0] hit_idx;
    logic          accept;
    logic          tmo;

    // Descending scan so the lowest matching slot overrides higher ones.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        S_HSEL  = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((HADDR & ADDR_MASK) == SLAVE_BASE[32*i +: 32]) begin
                hit_any   = 1'b1;
                hit_idx   = IW'(i);
                S_HSEL    = '0;
                S_HSEL[i] = 1'b1;
            end
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        case (sel_q)
            SEL_SLOT: begin
                HREADY = S_HREADYOUT[idx_q];
                HRESP  = S_HRESP[idx_q];
                HRDATA = S_HRDATA[32*idx_q +: 32];
            end
            SEL_DFLT: begin
                HREADY = (state_q == ST_ERR2);
                HRESP  = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept = HREADY;

`ifdef AHBL_SPLITTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_q, wait_d;
    logic          stalled;

    assign stalled = (sel_q == SEL_SLOT) && !S_HREADYOUT[idx_q];
    // Fires on the last permitted wait cycle so ERR1 follows exactly TIMEOUT_CYCLES stalls.
    assign tmo     = stalled && (wait_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_d = wait_q;
        if (accept)       wait_d = '0;
        else if (stalled) wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) wait_q <= '0;
        else        wait_q <= wait_d;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        sel_d   = sel_q;
        idx_d   = idx_q;
        state_d = state_q;
        err_d   = err_q;
        if (state_q == ST_ERR1)      state_d = ST_ERR2;
        else if (state_q == ST_ERR2) state_d = ST_IDLE;
        if (accept) begin
            if (HTRANS[1] && hit_any) begin
                sel_d = SEL_SLOT;
                idx_d = hit_idx;
            end else if (HTRANS[1]) begin
                sel_d   = SEL_DFLT;
                state_d = ST_ERR1;
            end else begin
                sel_d = SEL_NONE;
            end
        end
        if (tmo) begin
            sel_d   = SEL_DFLT;
            state_d = ST_ERR1;
        end
        if (state_d == ST_ERR1 && state_q != ST_ERR1 && err_q != 16'hFFFF)
            err_d = err_q + 16'd1;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_q   <= SEL_NONE;
            idx_q   <= '0;
            state_q <= ST_IDLE;
            err_q   <= '0;
        end else begin
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign ERR_COUNT = err_q;
endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Scoreboard bench for ahbl_splitter_n: directed steps push expectations, a negedge monitor checks.
module tb_ahbl_splitter_n;
`ifdef AHBL_SPLITTER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 256;
`endif
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = IDLE;
    logic        HREADY, HRESP;
    logic [31:0] HRDATA;
    logic [2:0]  S_HSEL;
    logic [95:0] S_HRDATA = {32'h2222_2222, 32'hABCD_EF01, 32'h1111_0000};
    logic [2:0]  S_HREADYOUT = 3'b111;
    logic [2:0]  S_HRESP = 3'b000;
    logic [15:0] ERR_COUNT;

    ahbl_splitter_n #(.N_SLAVES(3), .TIMEOUT_CYCLES(TMO)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .S_HSEL(S_HSEL),
        .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
        .ERR_COUNT(ERR_COUNT)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       nm;
        logic [2:0]  hsel;
        logic        rdy;
        logic        rsp;
        logic [31:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;

    always @(negedge HCLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (S_HSEL === e.hsel && HREADY === e.rdy && HRESP === e.rsp &&
                HRDATA === e.data && ERR_COUNT === e.cnt)
                passed++;
            else
                $display("FAIL %s: got hsel=%b rdy=%b rsp=%b data=%h cnt=%0d want hsel=%b rdy=%b rsp=%b data=%h cnt=%0d",
                         e.nm, S_HSEL, HREADY, HRESP, HRDATA, ERR_COUNT,
                         e.hsel, e.rdy, e.rsp, e.data, e.cnt);
        end
    end

    task automatic step(input string nm, input logic rst, input logic [31:0] a, input logic [1:0] t,
                        input logic [2:0] rdy, input logic [2:0] rsp,
                        input logic [2:0] e_hsel, input logic e_rdy, input logic e_rsp,
                        input logic [31:0] e_data, input logic [15:0] e_cnt);
        exp_t e;
        @(posedge HCLK);
        #1;
        HRESET = rst; HADDR = a; HTRANS = t; S_HREADYOUT = rdy; S_HRESP = rsp;
        e.nm = nm; e.hsel = e_hsel; e.rdy = e_rdy; e.rsp = e_rsp; e.data = e_data; e.cnt = e_cnt;
        q.push_back(e);
    endtask

    initial begin
        // reset state: decode still live, data phase idle
        step("reset",      1, 32'h0000_0000, IDLE, 3'b111, 3'b000, 3'b001, 1, 0, 32'h0, 0);
        // single zero-wait read to slot 1
        step("t1_addr",    0, 32'h1000_0004, NSEQ, 3'b111, 3'b000, 3'b010, 1, 0, 32'h0, 0);
        step("t1_data",    0, 32'h0000_0000, IDLE, 3'b111, 3'b000, 3'b001, 1, 0, 32'hABCD_EF01, 0);
        step("t1_idle",    0, 32'h0000_0000, IDLE, 3'b111, 3'b000, 3'b001, 1, 0, 32'h0, 0);
        // slot 2 with three wait states, slot 0 address held behind it
        step("t2_addr",    0, 32'h2000_0000, NSEQ, 3'b111, 3'b000, 3'b100, 1, 0, 32'h0, 0);
        step("t2_wait1",   0, 32'h0000_0000, NSEQ, 3'b011, 3'b000, 3'b001, 0, 0, 32'h2222_2222, 0);
        step("t2_wait2",   0, 32'h0000_0000, NSEQ, 3'b011, 3'b000, 3'b001, 0, 0, 32'h2222_2222, 0);
        step("t2_wait3",   0, 32'h0000_0000, NSEQ, 3'b011, 3'b000, 3'b001, 0, 0, 32'h2222_2222, 0);
        step("t2_done",    0, 32'h0000_0000, NSEQ, 3'b111, 3'b000, 3'b001, 1, 0, 32'h2222_2222, 0);
        step("t2_s0data",  0, 32'h3000_0000, IDLE, 3'b111, 3'b000, 3'b000, 1, 0, 32'h1111_0000, 0);
        // unmapped transfer, then two back-to-back
        step("t3_addr",    0, 32'h5000_0000, NSEQ, 3'b111, 3'b000, 3'b000, 1, 0, 32'h0, 0);
        step("t3_err1",    0, 32'h3000_0000, IDLE, 3'b111, 3'b000, 3'b000, 0, 1, 32'h0, 1);
        step("t3_err2",    0, 32'h3000_0000, IDLE, 3'b111, 3'b000, 3'b000, 1, 1, 32'h0, 1);
        step("t3_after",   0, 32'h3000_0000, IDLE, 3'b111, 3'b000, 3'b000, 1, 0, 32'h0, 1);
        step("t3b_addr",   0, 32'h5000_0000, NSEQ, 3'b111, 3'b000, 3'b000, 1, 0, 32'h0, 1);
        step("t3b_err1a",  0, 32'h6000_0000, NSEQ, 3'b111, 3'b000, 3'b000, 0, 1, 32'h0, 2);
        step("t3b_err2a",  0, 32'h6000_0000, NSEQ, 3'b111, 3'b000, 3'b000, 1, 1, 32'h0, 2);
        step("t3b_err1b",  0, 32'h3000_0000, IDLE, 3'b111, 3'b000, 3'b000, 0, 1, 32'h0, 3);
        step("t3b_err2b",  0, 32'h3000_0000, IDLE, 3'b111, 3'b000, 3'b000, 1, 1, 32'h0, 3);
        step("t3b_after",  0, 32'h3000_0000, IDLE, 3'b111, 3'b000, 3'b000, 1, 0, 32'h0, 3);
        // pipelined slot0 -> slot1 -> IDLE, then BUSY is not a transfer
        step("t4_a0",      0, 32'h0000_0000, NSEQ, 3'b111, 3'b000, 3'b001, 1, 0, 32'h0, 3);
        step("t4_a1",      0, 32'h1000_0000, SEQ,  3'b111, 3'b000, 3'b010, 1, 0, 32'h1111_0000, 3);
        step("t4_idle",    0, 32'h2000_0000, IDLE, 3'b111, 3'b000, 3'b100, 1, 0, 32'hABCD_EF01, 3);
        step("t4_idledat", 0, 32'h0000_0000, IDLE, 3'b111, 3'b000, 3'b001, 1, 0, 32'h0, 3);
        step("t4_busy",    0, 32'h1000_0000, BUSY, 3'b111, 3'b000, 3'b010, 1, 0, 32'h0, 3);
        step("t4_busydat", 0, 32'h1000_0000, IDLE, 3'b111, 3'b000, 3'b010, 1, 0, 32'h0, 3);
        // slot error response passes through
        step("t4_rsp_a",   0, 32'h1000_0000, NSEQ, 3'b111, 3'b000, 3'b010, 1, 0, 32'h0, 3);
        step("t4_rsp_d",   0, 32'h0000_0000, IDLE, 3'b111, 3'b010, 3'b001, 1, 1, 32'hABCD_EF01, 3);
        // reset in the middle of a slot-1 wait state
        step("t5_addr",    0, 32'h1000_0000, NSEQ, 3'b111, 3'b000, 3'b010, 1, 0, 32'h0, 3);
        step("t5_wait",    0, 32'h2000_0000, IDLE, 3'b101, 3'b000, 3'b100, 0, 0, 32'hABCD_EF01, 3);
        step("t5_rst",     1, 32'h2000_0000, IDLE, 3'b101, 3'b000, 3'b100, 1, 0, 32'h0, 0);
        step("t5_new",     0, 32'h0000_0000, NSEQ, 3'b111, 3'b000, 3'b001, 1, 0, 32'h0, 0);
        step("t5_newdat",  0, 32'h0000_0000, IDLE, 3'b111, 3'b000, 3'b001, 1, 0, 32'h1111_0000, 0);
`ifdef AHBL_SPLITTER_TIMEOUT_EN
        // slot 0 never becomes ready: eight stalls then the default ERROR
        step("t6_addr",    0, 32'h0000_0000, NSEQ, 3'b111, 3'b000, 3'b001, 1, 0, 32'h0, 0);
        for (int i = 0; i < 8; i++)
            step("t6_stall", 0, 32'h3000_0000, IDLE, 3'b110, 3'b000, 3'b000, 0, 0, 32'h1111_0000, 0);
        step("t6_err1",    0, 32'h3000_0000, IDLE, 3'b110, 3'b000, 3'b000, 0, 1, 32'h0, 1);
        step("t6_err2",    0, 32'h3000_0000, IDLE, 3'b110, 3'b000, 3'b000, 1, 1, 32'h0, 1);
        step("t6_resume",  0, 32'h3000_0000, IDLE, 3'b110, 3'b000, 3'b000, 1, 0, 32'h0, 1);
`endif
        repeat (3) @(posedge HCLK);
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending want 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
